// File: rtl/zc_period_meter.sv
// zc_period_meter: rising zero-crossing detector with hysteresis, period averaging and timeout.
// Define ZC_GLITCH_FILTER_EN to require each threshold condition on two consecutive valid samples.
module zc_period_meter #(
   parameter int unsigned DATA_W   = 10,
   parameter int unsigned CNT_W    = 20,
   parameter int unsigned HYST     = 16,
   parameter int unsigned AVG_LOG2 = 2
) (
   input  logic              sys_clk,
   input  logic              sys_rst,
   input  logic [DATA_W-1:0] data_in,
   input  logic              data_valid,
   output logic [CNT_W-1:0]  period_out,
   output logic              period_valid,
   output logic              signal_lost
);

   localparam int unsigned ACC_W = CNT_W + AVG_LOG2;
   localparam int unsigned AVG_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

   localparam logic signed [DATA_W-1:0] HYST_POS = DATA_W'(HYST);
   localparam logic signed [DATA_W-1:0] HYST_NEG = -HYST_POS;
   localparam logic        [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
   localparam logic        [AVG_W-1:0]  AVG_ONE  = AVG_W'(1);
   localparam logic        [AVG_W-1:0]  AVG_LAST = AVG_W'((1 << AVG_LOG2) - 1);

   typedef enum logic [1:0] {StSeek, StArm, StRunHi, StRunLo} state_e;

   state_e             r_state, w_state_nxt;
   logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
   logic [ACC_W-1:0]   r_acc, w_acc_nxt;
   logic [AVG_W-1:0]   r_avg_n, w_avg_n_nxt;
   logic [CNT_W-1:0]   r_period, w_period_nxt;
   logic               r_pvalid, w_pvalid_nxt;
   logic               r_lost, w_lost_nxt;

   logic signed [DATA_W-1:0] w_sample;
   logic                     w_hi_raw, w_lo_raw, w_hi, w_lo;
   logic                     w_cnt_max, w_timeout;
   logic [ACC_W-1:0]         w_acc_sum;

   assign w_sample = data_in;
   assign w_hi_raw = (w_sample >= HYST_POS);
   assign w_lo_raw = (w_sample <= HYST_NEG);

`ifdef ZC_GLITCH_FILTER_EN
   // Condition seen on the previous valid sample; strobe-low clocks do not disturb it.
   logic r_hi_prev, r_lo_prev;

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         r_hi_prev <= 1'b0;
         r_lo_prev <= 1'b0;
      end else if (data_valid) begin
         r_hi_prev <= w_hi_raw;
         r_lo_prev <= w_lo_raw;
      end
   end

   assign w_hi = w_hi_raw & r_hi_prev;
   assign w_lo = w_lo_raw & r_lo_prev;
`else
   assign w_hi = w_hi_raw;
   assign w_lo = w_lo_raw;
`endif

   assign w_cnt_max = &r_cnt;
   assign w_acc_sum = r_acc + ACC_W'(r_cnt);

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         r_state  <= StSeek;
         r_cnt    <= '0;
         r_acc    <= '0;
         r_avg_n  <= '0;
         r_period <= '0;
         r_pvalid <= 1'b0;
         r_lost   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_acc    <= w_acc_nxt;
         r_avg_n  <= w_avg_n_nxt;
         r_period <= w_period_nxt;
         r_pvalid <= w_pvalid_nxt;
         r_lost   <= w_lost_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_acc_nxt    = r_acc;
      w_avg_n_nxt  = r_avg_n;
      w_period_nxt = r_period;
      w_pvalid_nxt = 1'b0;
      w_lost_nxt   = r_lost;
      w_timeout    = 1'b0;
      if (data_valid) begin
         unique case (r_state)
            StSeek: begin
               if (w_lo) w_state_nxt = StArm;
            end
            StArm: begin
               if (w_hi) begin
                  w_state_nxt = StRunHi;
                  w_cnt_nxt   = CNT_ONE;
                  w_acc_nxt   = '0;
                  w_avg_n_nxt = '0;
               end else if (w_cnt_max) begin
                  w_timeout = 1'b1;
               end else begin
                  w_cnt_nxt = r_cnt + CNT_ONE;
               end
            end
            StRunHi: begin
               if (w_cnt_max) begin
                  w_timeout = 1'b1;
               end else begin
                  w_cnt_nxt = r_cnt + CNT_ONE;
                  if (w_lo) w_state_nxt = StRunLo;
               end
            end
            StRunLo: begin
               // The closing crossing captures cnt as-is, so it always beats the timeout.
               if (w_hi) begin
                  w_state_nxt = StRunHi;
                  w_cnt_nxt   = CNT_ONE;
                  w_acc_nxt   = w_acc_sum;
                  w_avg_n_nxt = r_avg_n + AVG_ONE;
                  if (r_avg_n == AVG_LAST) begin
                     w_period_nxt = CNT_W'(w_acc_sum >> AVG_LOG2);
                     w_acc_nxt    = '0;
                     w_avg_n_nxt  = '0;
                     w_pvalid_nxt = 1'b1;
                     w_lost_nxt   = 1'b0;
                  end
               end else if (w_cnt_max) begin
                  w_timeout = 1'b1;
               end else begin
                  w_cnt_nxt = r_cnt + CNT_ONE;
               end
            end
            default: w_state_nxt = StSeek;
         endcase
         if (w_timeout) begin
            w_state_nxt = StSeek;
            w_cnt_nxt   = '0;
            w_acc_nxt   = '0;
            w_avg_n_nxt = '0;
            w_lost_nxt  = 1'b1;
         end
      end
   end

   assign period_out   = r_period;
   assign period_valid = r_pvalid;
   assign signal_lost  = r_lost;

endmodule
